addsub_seq: RTL

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, least-significant chunk first. It replaces the fixed 4-bit ripple add/sub as the arithmetic unit of the lab datapath. The block adds a start/busy/done handshake, registered results and a full flag set (carry, signed overflow, zero, negative). The chunk size trades ripple depth against latency.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/chunk_addsub.sv | 29 ++
 rtl/addsub_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state encoding and sizing helper for addsub_seq
// Contents: FSM state constants (IDLE, RUN) and cnt_width(), the bit width
// of a 0..n-1 chunk counter (minimum 1 bit).
package addsub_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_addsub.sv
// rtl/chunk_addsub.sv - combinational CHUNK-bit ripple adder slice
// Ports: x, y (CHUNK-bit addends), cin (carry in);
//        s (CHUNK-bit sum), cout (carry out of bit CHUNK-1),
//        msb_cin (carry into bit CHUNK-1, used for signed overflow).
module chunk_addsub #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        cout    = c[CHUNK];
        msb_cin = c[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle add/subtract, CHUNK bits per clock, LS chunk first
// Ports: clk, rst (async, active-high); start, sub, a, b (request);
//        busy, done (handshake); result, carry, overflow, zero, negative
//        (registered, held until the next completion).
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             cin_r;

    logic [CHUNK-1:0] sum_chunk;
    logic             chunk_cout;
    logic             chunk_msb_cin;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    chunk_addsub #(.CHUNK(CHUNK)) u_chunk (
        .x       (op_a[CHUNK-1:0]),
        .y       (op_b[CHUNK-1:0]),
        .cin     (cin_r),
        .s       (sum_chunk),
        .cout    (chunk_cout),
        .msb_cin (chunk_msb_cin)
    );

    // Sum chunks enter at the top; after N shifts the first chunk sits at bit 0.
    always_comb begin
        acc_next = acc >> CHUNK;
        acc_next[WIDTH-1 -: CHUNK] = sum_chunk;
    end

    assign last = (cnt == CW'(N - 1));
    assign busy = (state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cin_r    <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction as a + ~b + 1: invert b now, carry-in of 1.
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        cin_r <= sub;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    acc   <= acc_next;
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    cin_r <= chunk_cout;
                    if (last) begin
                        result   <= acc_next;
                        carry    <= chunk_cout;
                        overflow <= chunk_msb_cin ^ chunk_cout;
                        zero     <= (acc_next == '0);
                        negative <= acc_next[WIDTH-1];
                        done     <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule
